// File: rtl/snake_tick_gen_pkg.sv
// snake_tick_gen_pkg: state encoding and default width shared with the snake counter blocks.
package snake_tick_gen_pkg;
  localparam int DEF_WIDTH = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_e;
endpackage

// File: rtl/snake_tick_gen_if.sv
// snake_tick_gen_if: control strobes from the speed/level logic and tick/status back to it.
interface snake_tick_gen_if
  import snake_tick_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             load;
  logic             start;
  logic             pause;
  logic             stop;
  logic             tick;
  logic             running;
  logic             paused;
  logic             load_err;
  modport master(output period, load, start, pause, stop,
                 input tick, count, running, paused, load_err);
  modport slave(input period, load, start, pause, stop,
                output tick, count, running, paused, load_err);
endinterface

// File: rtl/snake_tick_gen_tick_prescaler.sv
// tick_prescaler: divides the clock into count steps; advances only while run is high.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic step
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  assign step = run && pre_q == PW'(PRESCALE - 1);
  always_comb pre_d = (clear || step) ? '0 : run ? pre_q + 1'b1 : pre_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
endmodule

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: programmable-period down-counting tick generator with load/start/pause/stop.
module snake_tick_gen
  import snake_tick_gen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 50000
) (
  input logic             clock,
  input logic             reset,
  snake_tick_gen_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d, count_q, count_d;
  logic             tick_q, tick_d, err_q, err_d;
  logic             ld_ok, start_go, run, step;
  assign ld_ok    = bus.load && bus.period != '0;
  assign start_go = state_q == IDLE && bus.start && !bus.stop;
  // a pause or stop edge swallows any step due in that cycle
  assign run      = state_q == RUN && !bus.pause && !bus.stop;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clock(clock),
    .reset(reset),
    .run  (run),
    .clear(start_go || bus.stop),
    .step (step)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb
    state_d = bus.stop         ? IDLE :
              state_q == IDLE  ? (bus.start ? RUN : IDLE) :
              state_q == RUN   ? (bus.pause ? PAUSED : RUN) :
              (bus.pause || bus.start) ? RUN : PAUSED;
  always_comb begin
    period_d = ld_ok ? bus.period : period_q;
    count_d  = bus.stop ? '0 :
               start_go ? period_d - WIDTH'(1) :
               (run && step) ? (count_q == '0 ? period_d - WIDTH'(1) : count_q - WIDTH'(1)) :
               count_q;
    tick_d   = run && step && count_q == '0;
    err_d    = bus.load && bus.period == '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      period_q <= WIDTH'(1);
      count_q  <= '0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  always_comb begin
    bus.running  = state_q == RUN;
    bus.paused   = state_q == PAUSED;
    bus.tick     = tick_q;
    bus.count    = count_q;
    bus.load_err = err_q;
  end
endmodule

// File: tb/tb_snake_tick_gen.sv
// tb_snake_tick_gen: table-driven vectors through a scoreboard queue, PRESCALE=1 and PRESCALE=2 instances.
module tb_snake_tick_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  snake_tick_gen_if #(.WIDTH(10)) ia ();
  snake_tick_gen_if #(.WIDTH(10)) ib ();
  snake_tick_gen #(.WIDTH(10), .PRESCALE(1)) ua (.clock(clk), .reset(rst), .bus(ia.slave));
  snake_tick_gen #(.WIDTH(10), .PRESCALE(2)) ub (.clock(clk), .reset(rst), .bus(ib.slave));
  typedef struct {
    logic [9:0] per;
    logic       ld, st, pa, sp;
    int         rep;
    logic [9:0] cnt;
    logic       tk, rn, pz, er;
  } vec_t;
  typedef struct {
    bit         b;
    int         id;
    logic [9:0] cnt;
    logic       tk, rn, pz, er;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  function automatic vec_t mk(int per, bit ld, bit st, bit pa, bit sp, int rep,
                              int cnt, bit tk, bit rn, bit pz, bit er);
    vec_t v;
    v.per = 10'(per); v.ld = ld; v.st = st; v.pa = pa; v.sp = sp; v.rep = rep;
    v.cnt = 10'(cnt); v.tk = tk; v.rn = rn; v.pz = pz; v.er = er;
    return v;
  endfunction
  task automatic drive(input vec_t v, input bit b);
    ia.period = '0; ia.load = 0; ia.start = 0; ia.pause = 0; ia.stop = 0;
    ib.period = '0; ib.load = 0; ib.start = 0; ib.pause = 0; ib.stop = 0;
    if (b) begin
      ib.period = v.per; ib.load = v.ld; ib.start = v.st; ib.pause = v.pa; ib.stop = v.sp;
    end else begin
      ia.period = v.per; ia.load = v.ld; ia.start = v.st; ia.pause = v.pa; ia.stop = v.sp;
    end
  endtask
  task automatic check_out;
    exp_t e;
    logic [9:0] c;
    logic t, r, p, er;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e  = sb.pop_front();
    c  = e.b ? ib.count    : ia.count;
    t  = e.b ? ib.tick     : ia.tick;
    r  = e.b ? ib.running  : ia.running;
    p  = e.b ? ib.paused   : ia.paused;
    er = e.b ? ib.load_err : ia.load_err;
    checks++;
    if ({c, t, r, p, er} !== {e.cnt, e.tk, e.rn, e.pz, e.er}) begin
      errors++;
      $display("FAIL vec%0d dut_%s got count=%0d tick=%b running=%b paused=%b load_err=%b want count=%0d tick=%b running=%b paused=%b load_err=%b",
               e.id, e.b ? "b" : "a", c, t, r, p, er, e.cnt, e.tk, e.rn, e.pz, e.er);
    end
  endtask
  task automatic apply(input vec_t v, input bit b, input int id);
    for (int r = 0; r < v.rep; r++) begin
      drive(v, b);
      sb.push_back('{b, id, v.cnt, v.tk, v.rn, v.pz, v.er});
      @(posedge clk);
      @(negedge clk);
      check_out();
    end
  endtask
  task automatic expect_zero(input int id);
    sb.push_back('{1'b0, id, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check_out();
  endtask
  initial begin
    // PRESCALE=1: basic period, pause/hold/resume, load errors, load timing, strobe priority
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0));
    tbl.push_back(mk(4,1,0,0,0,1,  0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  3,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  3,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  3,1,1,0,0));
    tbl.push_back(mk(5,1,0,0,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  4,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  3,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,  2,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,10, 2,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  4,1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,1,  3,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  4,1,1,0,0));
    tbl.push_back(mk(2,1,0,0,0,1,  3,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(3,1,0,0,0,1,  2,1,1,0,0));
    tbl.push_back(mk(0,0,1,1,1,1,  0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,  0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0,1,  2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  1,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  2,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,  0,0,0,0,0));
    tbl.push_back(mk(6,1,1,0,0,1,  5,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,  5,0,0,1,0));
    tbl.push_back(mk(0,0,1,0,0,1,  5,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  4,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1,  4,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,1,  0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,  5,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  4,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,  3,0,1,0,0));
    drive(mk(0,0,0,0,0,1,0,0,0,0,0), 1'b0);
    repeat (2) @(negedge clk);
    expect_zero(900);
    rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i], 1'b0, i);
    // asynchronous reset mid-period, observed before any clock edge
    drive(mk(0,0,0,0,0,1,0,0,0,0,0), 1'b0);
    #2 rst = 1'b1;
    #1 expect_zero(901);
    @(negedge clk);
    expect_zero(902);
    rst = 1'b0;
    apply(mk(0,0,0,0,0,3, 0,0,0,0,0), 1'b0, 903);
    apply(mk(0,0,1,0,0,1, 0,0,1,0,0), 1'b0, 904);
    apply(mk(0,0,0,0,0,3, 0,1,1,0,0), 1'b0, 905);
    apply(mk(0,0,0,0,1,1, 0,0,0,0,0), 1'b0, 906);
    // PRESCALE=2: period 3 loaded together with start, tick every 6 cycles
    apply(mk(3,1,1,0,0,1, 2,0,1,0,0), 1'b1, 1000);
    for (int k = 1; k <= 18; k++)
      apply(mk(0,0,0,0,0,1, 2 - ((k / 2) % 3), (k % 6) == 0, 1, 0, 0), 1'b1, 1000 + k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_tick_gen.md
Name: snake_tick_gen

Overview:
- Programmable-period down-counting tick generator.
- Produces the single-cycle advance strobes that the 10-bit up-counters consume on their enable inputs.
- Sits between the speed/level control logic and the snake position/score counters.
- Supports load, start, pause and stop of the game clock, so snake speed can change between moves without glitching a move.

Parameters:
- WIDTH, 10: width of the period and count registers.
- PRESCALE, 50000: clock cycles per count step (1 ms at 50 MHz); must be >= 1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- period  input  WIDTH  requested ticks interval, in count steps; 0 is illegal.
- load  input  1  one-cycle strobe: capture period.
- start  input  1  one-cycle strobe: begin generating ticks.
- pause  input  1  one-cycle strobe: toggle between RUN and PAUSED.
- stop  input  1  one-cycle strobe: return to IDLE.
- tick  output  1  one-cycle advance strobe, registered.
- count  output  WIDTH  current down-count value.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSED.
- load_err  output  1  one-cycle pulse: load was attempted with period == 0.

Behaviour:
- Reset (asynchronous, any time including mid-period):
  - state = IDLE; period_q = 1; count = 0; prescaler = 0.
  - tick, running, paused, load_err all = 0.
- Load:
  - load with period != 0: period_q <= period next edge, in any state.
  - load with period == 0: period_q unchanged; load_err = 1 for exactly one cycle.
  - Load in RUN/PAUSED does not disturb count; the new period_q applies at the next reload.
- Step strobe:
  - Internal prescaler counts 0..PRESCALE-1 while in RUN only.
  - step = 1 in the cycle the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - PRESCALE = 1 gives step = 1 every RUN cycle.
- FSM states: IDLE, RUN, PAUSED.
  - IDLE -> RUN on start. count <= (value of period_q that start uses) - 1; prescaler <= 0.
  - RUN -> PAUSED on pause. count and prescaler are held.
  - PAUSED -> RUN on pause or start. Resumes from the held count/prescaler; no reload.
  - RUN or PAUSED -> IDLE on stop. count <= 0; prescaler <= 0.
  - start while in RUN is ignored.
  - pause while in IDLE is ignored.
- Counting in RUN, on each step:
  - count != 0: count <= count - 1.
  - count == 0: count <= period_q - 1, and tick <= 1 on the same edge.
  - tick is high for exactly one cycle per reload.
  - Tick interval = period_q * PRESCALE cycles.
  - period_q = 1 gives a tick every PRESCALE cycles (every cycle when PRESCALE = 1).
- Simultaneous strobes, priority stop > pause > start:
  - stop + any other strobe: -> IDLE.
  - pause + start in IDLE: start wins, since pause is ignored in IDLE.
  - load + start in the same cycle: start uses the newly loaded period (period_q bypass).
  - load + reload step in the same cycle: the reload uses the new period.
- tick is never asserted outside RUN. A pending step at a pause/stop edge is discarded.
- Outputs:
  - running/paused are decoded from registered state; no combinational path from inputs.
  - count is WIDTH bits unsigned; no wrap below 0 is possible.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2;
  - the default WIDTH = 10, shared with the counter blocks.
- One sub-module, tick_prescaler (PRESCALE parameter).
  - Inputs: clock, reset, run, clear.
  - Output: step.

Test Plan:
- PRESCALE = 1; load period = 4, start. Ticks at cycles 4, 8, 12 after start; count sequence 3, 2, 1, 0, 3, ...
- PRESCALE = 2; period = 3, start. Tick every 6 cycles; count steps every 2nd cycle.
- PRESCALE = 1; period = 5, running. Pause at count = 2; hold 10 cycles with count = 2 and tick = 0; pause again. Tick arrives 3 cycles later.
- Load period = 0. load_err pulses once; period_q unchanged, confirmed by the next tick interval. Then load 2 while running: current interval finishes at the old length, next interval is 2.
- stop + pause + start in the same cycle while in RUN -> IDLE, count = 0, running = 0.
- Assert reset mid-period (count = 3): all outputs 0 asynchronously. After release, no tick until start.
